// File: rtl/irq_arb_pkg.sv
// Shared constants and state encoding for the interrupt service arbiter.
package irq_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 255;

  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_GRANT = 3'b010;
  localparam logic [2:0] ST_WAIT  = 3'b100;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    GRANT     = ST_GRANT,
    WAIT_DONE = ST_WAIT
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: finds the first eligible requester strictly
// after ptr, wrapping around. Purely combinational.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner_id,
  output logic [N_REQ-1:0] winner_oh,
  output logic             any_valid
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  int                 start_idx;
  int                 hit_idx;

  // Rotate so bit 0 of rot is requester ptr+1, then take the lowest set bit
  // and map it back to an absolute index.
  always_comb begin
    start_idx = int'(ptr) + 1;
    dbl       = {elig, elig} >> start_idx;
    rot       = dbl[N_REQ-1:0];
    any_valid = 1'b0;
    hit_idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rot[i] && !any_valid) begin
        any_valid = 1'b1;
        hit_idx   = start_idx + i;
      end
    end
    if (hit_idx >= N_REQ) begin
      hit_idx = hit_idx - N_REQ;
    end
    winner_id = ID_W'(hit_idx);
    winner_oh = any_valid ? (N_REQ'(1) << hit_idx) : '0;
  end

endmodule

// File: rtl/irq_rr_service_arbiter.sv
// Shares one interrupt service engine among N_REQ requesters. Request pulses
// are latched into a sticky pending vector, masked, and served round-robin
// with a held one-hot grant and a single-cycle irq pulse.
// Optional: define ARB_TIMEOUT_EN to build a WAIT_DONE watchdog that
// force-releases a grant after TIMEOUT cycles and pulses timeout_err.
module irq_rr_service_arbiter
  import irq_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             irq,
  output logic             busy,
  output logic [N_REQ-1:0] pending,
  output logic             timeout_err
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             irq_q, irq_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] elig;
  logic [ID_W-1:0]  winner_id;
  logic [N_REQ-1:0] winner_oh;
  logic             any_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // TIMEOUT has no effect when the watchdog counter is not built.
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  assign elig = pending_q & mask;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .elig      (elig),
    .ptr       (ptr_q),
    .winner_id (winner_id),
    .winner_oh (winner_oh),
    .any_valid (any_valid)
  );

  // Next-state and registered-output logic for the IDLE/GRANT/WAIT_DONE FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    irq_d         = 1'b0;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    clr           = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (any_valid) begin
          state_d    = GRANT;
          grant_d    = winner_oh;
          grant_id_d = winner_id;
          ptr_d      = winner_id;
          clr        = winner_oh;
          irq_d      = 1'b1;
          busy_d     = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      GRANT: begin
        if (done) begin
          state_d    = IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          state_d    = IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_id_d    = '0;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
      end
    endcase

    // A fresh request on the bit being cleared wins, so it is re-queued.
    pending_d = (pending_q & ~clr) | req;
  end

  // State, pointer, pending and output registers; reset searches requester 0 first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      ptr_q         <= ID_W'(N_REQ - 1);
      irq_q         <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      irq_q         <= irq_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter for cycles spent waiting on the service engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign irq         = irq_q;
  assign busy        = busy_q;
  assign pending     = pending_q;
  assign timeout_err = timeout_err_q;

endmodule
